// File: rtl/chemical_safety_sequencer_if.sv
// Plant-side sensor/operator inputs and alarm/valve/status outputs of the tank safety sequencer.
interface chemical_safety_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             L;
    logic             T;
    logic             P;
    logic             M;
    logic             ack;
    logic             cnt_clr;
    logic             A;
    logic             V;
    logic [1:0]       state;
    logic [CNT_W-1:0] alarm_cnt;

    modport master (
        output L, T, P, M, ack, cnt_clr,
        input  A, V, state, alarm_cnt
    );

    modport slave (
        input  L, T, P, M, ack, cnt_clr,
        output A, V, state, alarm_cnt
    );
endinterface

// File: rtl/chemical_safety_sequencer.sv
// Chemical tank safety controller: sync + debounce of raw sensors, then a latched
// alarm / vent / lockout FSM with registered alarm and vent outputs and an event counter.
module chemical_safety_sequencer #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned VENT_MIN    = 16,
    parameter int unsigned HOLD_CYCLES = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    chemical_safety_sequencer_if.slave   bus
);

    localparam int unsigned N_SENS = 4;
    localparam int unsigned DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TMAX   = (VENT_MIN > HOLD_CYCLES) ? VENT_MIN : HOLD_CYCLES;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] VENT_LOAD = TW'(VENT_MIN - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_VENT    = 2'b01,
        ST_ALARM   = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    logic [N_SENS-1:0] w_raw;
    logic [N_SENS-1:0] r_sync1;
    logic [N_SENS-1:0] r_sync2;
    logic [N_SENS-1:0] r_deb;
    logic [DW-1:0]     r_deb_cnt [N_SENS];

    logic w_ld, w_td, w_pd, w_md;
    logic w_alarm_req;
    logic w_vent_req;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nxt;
    logic             r_a;
    logic             r_v;
    logic [CNT_W-1:0] r_alarm_cnt;
    logic [CNT_W-1:0] w_alarm_cnt_nxt;

    assign w_raw = {bus.M, bus.P, bus.T, bus.L};

    // Two-flop synchronisers for the asynchronous sensor pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-sensor debounce: a change is accepted only after DEB_CYCLES stable mismatching samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < N_SENS; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SENS; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_ld = r_deb[0];
    assign w_td = r_deb[1];
    assign w_pd = r_deb[2];
    assign w_md = r_deb[3];

    assign w_alarm_req = ~w_md & (w_ld | (w_td & w_pd));
    assign w_vent_req  = w_md | w_pd | (w_td & w_ld);

    // Next-state, shared vent/hold timer and event counter
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = (r_timer != '0) ? (r_timer - TW'(1)) : r_timer;
        w_alarm_cnt_nxt = r_alarm_cnt;

        case (r_state)
            ST_NORMAL: begin
                if (w_alarm_req) begin
                    w_state_nxt = ST_ALARM;
                end else if (w_vent_req) begin
                    w_state_nxt = ST_VENT;
                    w_timer_nxt = VENT_LOAD;
                end
            end
            ST_VENT: begin
                if (w_alarm_req) begin
                    w_state_nxt = ST_ALARM;
                end else if (!w_vent_req && (r_timer == '0)) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            ST_ALARM: begin
                if (bus.ack && !w_alarm_req) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_timer_nxt = HOLD_LOAD;
                end
            end
            ST_LOCKOUT: begin
                if (w_alarm_req) begin
                    w_state_nxt = ST_ALARM;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
            end
        endcase

        // Clear wins over a simultaneous ALARM entry
        if (bus.cnt_clr) begin
            w_alarm_cnt_nxt = '0;
        end else if ((w_state_nxt == ST_ALARM) && (r_state != ST_ALARM) &&
                     (r_alarm_cnt != '1)) begin
            w_alarm_cnt_nxt = r_alarm_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_NORMAL;
            r_timer     <= '0;
            r_a         <= 1'b0;
            r_v         <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_a         <= (w_state_nxt == ST_ALARM);
            r_v         <= (w_state_nxt != ST_NORMAL);
            r_alarm_cnt <= w_alarm_cnt_nxt;
        end
    end

    assign bus.A         = r_a;
    assign bus.V         = r_v;
    assign bus.state     = r_state;
    assign bus.alarm_cnt = r_alarm_cnt;

endmodule

// File: tb/tb_chemical_safety_sequencer.sv
// Directed bench for chemical_safety_sequencer: reset, debounce, vent minimum time,
// alarm latch/lockout, ack gating and event counter saturation/clear.
module tb_chemical_safety_sequencer;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    chemical_safety_sequencer_if #(.CNT_W(CNT_W)) bus ();

    chemical_safety_sequencer #(
        .DEB_CYCLES (4),
        .VENT_MIN   (16),
        .HOLD_CYCLES(32),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic a,
                           input logic v, input logic [CNT_W-1:0] cnt);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".A"}, 32'(bus.A), 32'(a));
        check({tag, ".V"}, 32'(bus.V), 32'(v));
        check({tag, ".cnt"}, 32'(bus.alarm_cnt), 32'(cnt));
    endtask

    task automatic do_reset();
        bus.L = 1'b0; bus.T = 1'b0; bus.P = 1'b0; bus.M = 1'b0;
        bus.ack = 1'b0; bus.cnt_clr = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // 1: reset with all hazards asserted, then 7-edge latency to ALARM
        rst_n = 1'b0;
        bus.L = 1'b1; bus.T = 1'b1; bus.P = 1'b1; bus.M = 1'b0;
        bus.ack = 1'b0; bus.cnt_clr = 1'b0;
        step(3);
        chk_out("rst_hold", 2'b00, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        step(6);
        chk_out("rst_edge6", 2'b00, 1'b0, 1'b0, 8'd0);
        step(1);
        chk_out("rst_edge7", 2'b10, 1'b1, 1'b1, 8'd1);

        // 2: short glitch rejected, long pulse accepted with exact latency
        do_reset();
        bus.L = 1'b1;
        step(3);
        bus.L = 1'b0;
        step(10);
        chk_out("deb_short", 2'b00, 1'b0, 1'b0, 8'd0);
        bus.L = 1'b1;
        step(6);
        bus.L = 1'b0;
        chk_out("deb_edge6", 2'b00, 1'b0, 1'b0, 8'd0);
        step(1);
        chk_out("deb_long", 2'b10, 1'b1, 1'b1, 8'd1);

        // 3: vent minimum on-time after a 10-cycle pressure pulse
        do_reset();
        bus.P = 1'b1;
        step(7);
        chk_out("vent_entry", 2'b01, 1'b0, 1'b1, 8'd0);
        step(3);
        bus.P = 1'b0;
        step(12);
        chk_out("vent_last", 2'b01, 1'b0, 1'b1, 8'd0);
        step(1);
        chk_out("vent_exit", 2'b00, 1'b0, 1'b0, 8'd0);

        // 4: alarm latch held without ack, then 32-cycle lockout
        do_reset();
        bus.T = 1'b1; bus.P = 1'b1;
        step(7);
        chk_out("latch_entry", 2'b10, 1'b1, 1'b1, 8'd1);
        bus.T = 1'b0; bus.P = 1'b0;
        step(50);
        chk_out("latch_hold", 2'b10, 1'b1, 1'b1, 8'd1);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        chk_out("lock_entry", 2'b11, 1'b0, 1'b1, 8'd1);
        step(31);
        chk_out("lock_last", 2'b11, 1'b0, 1'b1, 8'd1);
        step(1);
        chk_out("lock_exit", 2'b00, 1'b0, 1'b0, 8'd1);

        // 5: ack ignored while alarm requested; maintenance suppresses request only
        do_reset();
        bus.L = 1'b1;
        step(7);
        chk_out("ign_entry", 2'b10, 1'b1, 1'b1, 8'd1);
        bus.ack = 1'b1;
        step(3);
        bus.ack = 1'b0;
        chk_out("ign_ack", 2'b10, 1'b1, 1'b1, 8'd1);
        bus.M = 1'b1;
        step(8);
        chk_out("ign_maint", 2'b10, 1'b1, 1'b1, 8'd1);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        chk_out("ign_lock", 2'b11, 1'b0, 1'b1, 8'd1);
        // asynchronous reset mid-operation, sampled between edges
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 2'b00, 1'b0, 1'b0, 8'd0);
        step(1);
        rst_n = 1'b1;

        // 6: 260 alarm entries saturate the counter, clear beats simultaneous entry
        do_reset();
        bus.L = 1'b1;
        step(7);
        for (int i = 0; i < 259; i++) begin
            bus.L = 1'b0;
            step(7);
            bus.ack = 1'b1;
            step(1);
            bus.ack = 1'b0;
            bus.L = 1'b1;
            step(7);
            if (i == 98) begin
                chk_out("cnt_mid", 2'b10, 1'b1, 1'b1, 8'd100);
            end
        end
        chk_out("cnt_sat", 2'b10, 1'b1, 1'b1, 8'd255);
        bus.L = 1'b0;
        step(7);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        bus.L = 1'b1;
        step(6);
        chk_out("clr_pre", 2'b11, 1'b0, 1'b1, 8'd255);
        bus.cnt_clr = 1'b1;
        step(1);
        bus.cnt_clr = 1'b0;
        chk_out("clr_entry", 2'b10, 1'b1, 1'b1, 8'd0);
        bus.L = 1'b0;
        step(7);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        bus.L = 1'b1;
        step(7);
        chk_out("clr_after", 2'b10, 1'b1, 1'b1, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
